// File: rtl/if_program_ctrl.sv
// Instruction-fetch sequencing controller: assembles UART bytes into instruction words,
// writes them into IF memory, then runs or single-steps the pipeline until HALT.
module if_program_ctrl #(
    parameter int unsigned          INST_SZ   = 32,
    parameter int unsigned          DATA_SZ   = 8,
    parameter int unsigned          MEM_SZ    = 10,
    parameter logic [INST_SZ-1:0]   HALT_INST = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [DATA_SZ-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_halt_detected,
    output logic [INST_SZ-1:0] o_instruction,
    output logic               o_write,
    output logic [MEM_SZ-1:0]  o_wr_addr,
    output logic               o_enable,
    output logic               o_loaded,
    output logic               o_load_err,
    output logic [31:0]        o_cycle_count,
    output logic [2:0]         o_state
);

    localparam int unsigned BYTES = INST_SZ / DATA_SZ;
    localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CYC_W = 32;

    localparam logic [DATA_SZ-1:0] CMD_LOAD = DATA_SZ'(1);
    localparam logic [DATA_SZ-1:0] CMD_RUN  = DATA_SZ'(2);
    localparam logic [DATA_SZ-1:0] CMD_STEP = DATA_SZ'(3);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [INST_SZ-1:0] instr_q, instr_d;
    logic [MEM_SZ-1:0]  addr_q, addr_d;
    logic               loaded_q, loaded_d;
    logic               err_q, err_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic               write_q, write_d;
    logic               enable_q, enable_d;

    // State and output registers
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            instr_q  <= '0;
            addr_q   <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            cyc_q    <= '0;
            write_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            cyc_q    <= cyc_d;
            write_q  <= write_d;
            enable_q <= enable_d;
        end
    end

    // Next-state logic; strobes are derived from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        cyc_d    = cyc_q;

        if (enable_q && (cyc_q != '1)) begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD) begin
                        state_d  = ST_LOAD;
                        cnt_d    = '0;
                        addr_d   = '0;
                        loaded_d = 1'b0;
                        err_d    = 1'b0;
                        cyc_d    = '0;
                    end else if ((state_q == ST_IDLE) && loaded_q) begin
                        if (i_rx_data == CMD_RUN) begin
                            state_d = ST_RUN;
                        end else if (i_rx_data == CMD_STEP) begin
                            state_d = ST_STEP;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    instr_d = {instr_q[INST_SZ-DATA_SZ-1:0], i_rx_data};
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WRITE: begin
                // Address advances (and wraps) after every write; a full memory ends the load
                addr_d = addr_q + MEM_SZ'(1);
                if (instr_q == HALT_INST) begin
                    state_d  = ST_IDLE;
                    loaded_d = 1'b1;
                end else if (addr_q == '1) begin
                    state_d  = ST_IDLE;
                    loaded_d = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_halt_detected) begin
                    state_d = ST_DONE;
                end
            end
            ST_STEP: begin
                state_d = i_halt_detected ? ST_DONE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        write_d  = (state_d == ST_WRITE);
        enable_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    end

    assign o_instruction = instr_q;
    assign o_write       = write_q;
    assign o_wr_addr     = addr_q;
    assign o_enable      = enable_q;
    assign o_loaded      = loaded_q;
    assign o_load_err    = err_q;
    assign o_cycle_count = cyc_q;
    assign o_state       = state_q;

endmodule
